wb_voter: RTL and testbench
===========================

WB_VOTER -- requirements
Module: wb_voter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning number of redundant core write-back channels (legal: 2 or 3).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register-file address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning write data width.
REQ-004 SHALL have parameter TIMEOUT, default 15, meaning max cycles to wait for lagging channels (1..255).
REQ-005 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port valid_i  input  NUM_CH  per-channel write-back request.
REQ-008 SHALL have port ready_o  output  NUM_CH  per-channel accept; transfer when valid_i & ready_o.
REQ-009 SHALL have port we_i  input  NUM_CH  per-channel write enable.
REQ-010 SHALL have port addr_i  input  NUM_CH x ADDR_WIDTH  per-channel address.
REQ-011 SHALL have port data_i  input  NUM_CH x DATA_WIDTH  per-channel data.
REQ-012 SHALL have port commit_o  output  1  one-cycle pulse: voted write valid.
REQ-013 SHALL have port we_o / addr_o / data_o  output  1 / ADDR_WIDTH / DATA_WIDTH  voted write-back.
REQ-014 SHALL have port error_o  output  1  one-cycle pulse with any disagreement or timeout.
REQ-015 SHALL have port fault_mask_o  output  NUM_CH  channels outvoted or missing in last vote; held until next vote.

Function
REQ-016 SHALL implement FSM IDLE, COLLECT, VOTE; per-channel latch {we,addr,data} plus got flag.
REQ-017 ready_o[i] SHALL be 1 in IDLE/COLLECT while got[i]=0, else 0.
REQ-018 IDLE: any accepted valid SHALL latch those channels, clear timer; all NUM_CH accepted -> VOTE, else -> COLLECT.
REQ-019 COLLECT: timer SHALL increment each cycle; new accepts latched; all got -> VOTE; timer==TIMEOUT -> VOTE with missing channels.
REQ-020 Simultaneous last-accept and timer==TIMEOUT SHALL count as complete (no timeout).
REQ-021 VOTE SHALL last exactly one cycle, clear all got flags, return to IDLE; outputs registered, visible the cycle after VOTE.
REQ-022 Tuples compared as full {we,addr,data}; missing channel never matches.
REQ-023 NUM_CH=3: if >=2 latched tuples agree, commit_o=1 with majority tuple; dissenting/missing channels set in fault_mask_o; error_o=1 iff mask nonzero.
REQ-024 NUM_CH=3 with no majority, or NUM_CH=2 with any mismatch/missing: commit_o=0, error_o=1, fault_mask_o all ones.
REQ-025 Full agreement SHALL give commit_o=1, error_o=0, fault_mask_o=0.
REQ-026 we_o/addr_o/data_o SHALL hold last committed value when commit_o=0.
REQ-027 Latency: all channels valid same cycle -> commit_o two cycles after acceptance edge.

Reset
REQ-028 rst_ni low SHALL immediately force IDLE, got=0, timer=0, commit_o=0, error_o=0, we_o=0, addr_o=0, data_o=0, fault_mask_o=0; ready_o all ones after release.
REQ-029 Reset mid-COLLECT SHALL discard latched tuples with no commit or error.

Configuration
REQ-030 With WB_VOTER_ERRCNT_EN defined, SHALL add output err_cnt_o (NUM_CH x 8): per-channel saturating (255) count of votes where fault_mask_o bit set; reset 0.
REQ-031 Without WB_VOTER_ERRCNT_EN, port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package wb_voter_pkg SHALL hold state enum (IDLE, COLLECT, VOTE) and tuple struct type helpers; widths stay module parameters.
REQ-033 Sub-module wb_vote_core SHALL be purely combinational: latched tuples + got flags -> winning tuple, commit, fault mask.

Verification
REQ-034 NUM_CH=3, all valid cycle 0 with {1,5,0xDEADBEEF} -> commit_o cycle 2, addr_o=5, data_o=0xDEADBEEF, error_o=0.
REQ-035 NUM_CH=3, ch1 data 0x0 vs others 0x1234 -> commit data 0x1234, error_o=1, fault_mask_o=3'b010.
REQ-036 NUM_CH=3, ch0 at cycle 0, ch1 at cycle 3, ch2 never, TIMEOUT=15 -> vote at timeout, commit ch0 tuple, fault_mask_o=3'b100.
REQ-037 NUM_CH=2, addresses 3 vs 4 -> commit_o=0, error_o=1, fault_mask_o=2'b11.
REQ-038 rst_ni low in COLLECT after one accept -> no commit/error; next full triple votes normally.
REQ-039 With WB_VOTER_ERRCNT_EN, 300 votes with ch2 corrupted -> err_cnt_o[ch2]=255, others 0.

Source files
------------

// File: rtl/wb_voter_pkg.sv
// Shared types and helpers for the write-back voter: FSM states, timer and
// counter widths, and width helpers for the packed {we, addr, data} tuple.
package wb_voter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VOTE    = 2'd2
  } state_e;

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  // Tuples are packed MSB-first as {we, addr, data}.
  function automatic int unsigned tuple_width(input int unsigned aw, input int unsigned dw);
    return 32'd1 + aw + dw;
  endfunction

  // Agreeing channels needed for a commit: 2 of 3, or both of 2.
  function automatic int unsigned maj_threshold(input int unsigned n);
    return (n / 32'd2) + 32'd1;
  endfunction

endpackage

// File: rtl/wb_vote_core.sv
// Combinational vote over the latched per-channel tuples: picks the tuple
// shared by a majority of present channels and flags every channel that differs.
module wb_vote_core
  import wb_voter_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned TW     = 38
) (
  input  logic [NUM_CH*TW-1:0] tuples_i,
  input  logic [NUM_CH-1:0]    got_i,
  output logic [TW-1:0]        win_o,
  output logic                 commit_o,
  output logic [NUM_CH-1:0]    fault_mask_o
);

  localparam logic [3:0] THRESH = 4'(maj_threshold(NUM_CH));

  logic [3:0] cnt_s;
  logic       found_s;

  // Majority search; a missing channel never matches anything, itself included.
  always_comb begin
    cnt_s        = 4'd0;
    found_s      = 1'b0;
    win_o        = '0;
    fault_mask_o = '1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_s = 4'd0;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (got_i[i] && got_i[j] && (tuples_i[i*TW +: TW] == tuples_i[j*TW +: TW])) begin
          cnt_s = cnt_s + 4'd1;
        end else begin
          cnt_s = cnt_s;
        end
      end
      if (!found_s && (cnt_s >= THRESH)) begin
        found_s = 1'b1;
        win_o   = tuples_i[i*TW +: TW];
      end else begin
        found_s = found_s;
      end
    end
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (found_s) begin
        fault_mask_o[j] = ~(got_i[j] && (tuples_i[j*TW +: TW] == win_o));
      end else begin
        fault_mask_o[j] = 1'b1;
      end
    end
    commit_o = found_s;
  end

endmodule

// File: rtl/wb_voter.sv
// Redundant-core write-back voter: gathers one request per channel, votes, and
// emits a registered commit/error pulse. Define WB_VOTER_ERRCNT_EN for err_cnt_o.
module wb_voter
  import wb_voter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH-1:0]            valid_i,
  output logic [NUM_CH-1:0]            ready_o,
  input  logic [NUM_CH-1:0]            we_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic                         commit_o,
  output logic                         we_o,
  output logic [ADDR_WIDTH-1:0]        addr_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         error_o,
  output logic [NUM_CH-1:0]            fault_mask_o
`ifdef WB_VOTER_ERRCNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]      err_cnt_o
`endif
);

  localparam int unsigned TW = tuple_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);

  state_e                  state_q, state_d;
  logic [NUM_CH-1:0]       got_q, got_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [NUM_CH*TW-1:0]    tup_q, tup_d;
  logic [NUM_CH-1:0]       acc_s;

  logic [TW-1:0]           win_s;
  logic                    commit_s;
  logic [NUM_CH-1:0]       mask_s;

  logic                    commit_q, commit_d;
  logic                    error_q, error_d;
  logic [TW-1:0]           win_q, win_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;

  // Channels may hand over a request only while collecting and not yet latched.
  always_comb begin
    if ((state_q == IDLE) || (state_q == COLLECT)) begin
      ready_o = ~got_q;
    end else begin
      ready_o = '0;
    end
    acc_s = valid_i & ready_o;
  end

  // Collection FSM: latch accepted tuples, run the lag timer, decide when to vote.
  always_comb begin
    state_d = state_q;
    got_d   = got_q | acc_s;
    timer_d = timer_q;
    tup_d   = tup_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (acc_s[i]) begin
        tup_d[i*TW +: TW] = {we_i[i], addr_i[i*ADDR_WIDTH +: ADDR_WIDTH],
                             data_i[i*DATA_WIDTH +: DATA_WIDTH]};
      end else begin
        tup_d[i*TW +: TW] = tup_q[i*TW +: TW];
      end
    end
    case (state_q)
      IDLE: begin
        if (|acc_s) begin
          timer_d = '0;
          state_d = (&got_d) ? VOTE : COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        timer_d = timer_q + TIMER_W'(1);
        // A last accept landing on the timeout cycle still counts as complete.
        if (&got_d) begin
          state_d = VOTE;
        end else if (timer_q == TIMEOUT_C) begin
          state_d = VOTE;
        end else begin
          state_d = COLLECT;
        end
      end
      VOTE: begin
        got_d   = '0;
        timer_d = '0;
        state_d = IDLE;
      end
      default: begin
        got_d   = '0;
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  wb_vote_core #(
    .NUM_CH (NUM_CH),
    .TW     (TW)
  ) u_core (
    .tuples_i     (tup_q),
    .got_i        (got_q),
    .win_o        (win_s),
    .commit_o     (commit_s),
    .fault_mask_o (mask_s)
  );

  // Vote results are captured during VOTE; the write-back tuple holds until the next commit.
  always_comb begin
    commit_d = 1'b0;
    error_d  = 1'b0;
    win_d    = win_q;
    mask_d   = mask_q;
    if (state_q == VOTE) begin
      commit_d = commit_s;
      error_d  = |mask_s;
      mask_d   = mask_s;
      if (commit_s) begin
        win_d = win_s;
      end else begin
        win_d = win_q;
      end
    end else begin
      mask_d = mask_q;
    end
  end

  // FSM and latched-tuple state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      got_q   <= '0;
      timer_q <= '0;
      tup_q   <= '0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      timer_q <= timer_d;
      tup_q   <= tup_d;
    end
  end

  // Registered voter outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_q <= 1'b0;
      error_q  <= 1'b0;
      win_q    <= '0;
      mask_q   <= '0;
    end else begin
      commit_q <= commit_d;
      error_q  <= error_d;
      win_q    <= win_d;
      mask_q   <= mask_d;
    end
  end

  assign commit_o             = commit_q;
  assign error_o              = error_q;
  assign {we_o, addr_o, data_o} = win_q;
  assign fault_mask_o         = mask_q;

`ifdef WB_VOTER_ERRCNT_EN
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;

  // Per-channel saturating count of votes that flagged the channel.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if ((state_q == VOTE) && mask_s[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end else begin
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W];
      end
    end
  end

  // Fault counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_wb_voter.sv
// Self-checking bench for wb_voter: a 3-channel and a 2-channel instance driven
// from a directed table, hand sequences for reset, and randomized transactions.
module tb_wb_voter;

  localparam int TO = 15;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } tup_t;

  typedef struct {
    string       nm;
    int          nch;
    int          a0, a1, a2;
    tup_t        t0, t1, t2;
    logic        ec;
    logic [2:0]  em;
    tup_t        ew;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  v3, we3, r3, m3;
  logic [14:0] a3;
  logic [95:0] d3;
  logic        c3, w3o, e3;
  logic [4:0]  ao3;
  logic [31:0] do3;

  logic [1:0]  v2, we2, r2, m2;
  logic [9:0]  a2;
  logic [63:0] d2;
  logic        c2, w2o, e2;
  logic [4:0]  ao2;
  logic [31:0] do2;

`ifdef WB_VOTER_ERRCNT_EN
  logic [23:0] cnt3;
  logic [15:0] cnt2;
`endif

  wb_voter #(.NUM_CH(3), .ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(TO)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .ready_o(r3), .we_i(we3),
    .addr_i(a3), .data_i(d3), .commit_o(c3), .we_o(w3o), .addr_o(ao3),
    .data_o(do3), .error_o(e3), .fault_mask_o(m3)
`ifdef WB_VOTER_ERRCNT_EN
    , .err_cnt_o(cnt3)
`endif
  );

  wb_voter #(.NUM_CH(2), .ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT(TO)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .ready_o(r2), .we_i(we2),
    .addr_i(a2), .data_i(d2), .commit_o(c2), .we_o(w2o), .addr_o(ao2),
    .data_o(do2), .error_o(e2), .fault_mask_o(m2)
`ifdef WB_VOTER_ERRCNT_EN
    , .err_cnt_o(cnt2)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  int   cur_arr[3];
  tup_t cur_t[3];
  tup_t last_w[2];
  logic [2:0] last_m[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic tup_t mk(input logic we, input logic [4:0] addr, input logic [31:0] data);
    tup_t t;
    t.we = we; t.addr = addr; t.data = data;
    return t;
  endfunction

  function automatic tup_t rnd_tup();
    return mk(1'($urandom_range(0, 1)), 5'($urandom), 32'($urandom));
  endfunction

  function automatic tup_t corrupt(input tup_t t);
    tup_t r;
    r = t;
    case ($urandom_range(0, 2))
      0: r.we = ~t.we;
      1: r.addr = t.addr ^ 5'($urandom_range(1, 31));
      default: r.data = t.data ^ (32'($urandom) | 32'd1);
    endcase
    return r;
  endfunction

  // Cycle (counted from the start of the transaction) in which the voter sits in VOTE.
  function automatic int vote_cyc(input int nch);
    int t0, last;
    bit all;
    t0 = 1000; last = -1; all = 1'b1;
    for (int i = 0; i < nch; i++) begin
      if (cur_arr[i] < 0) all = 1'b0;
      else begin
        if (cur_arr[i] < t0) t0 = cur_arr[i];
        if (cur_arr[i] > last) last = cur_arr[i];
      end
    end
    if (all && (last - t0 - 1) <= TO) return last + 1;
    return t0 + TO + 2;
  endfunction

  // Reference outcome: the tuple held by enough present channels wins.
  task automatic model_vote(input int nch, output logic c, output logic [2:0] m, output tup_t w);
    int need, n;
    need = (nch == 3) ? 2 : nch;
    c = 1'b0; m = 3'b000; w = '0;
    for (int i = 0; i < nch; i++) begin
      if (cur_arr[i] >= 0 && !c) begin
        n = 0;
        for (int j = 0; j < nch; j++)
          if (cur_arr[j] >= 0 && cur_t[j] == cur_t[i]) n++;
        if (n >= need) begin c = 1'b1; w = cur_t[i]; end
      end
    end
    for (int i = 0; i < nch; i++)
      m[i] = c ? !(cur_arr[i] >= 0 && cur_t[i] == w) : 1'b1;
  endtask

  task automatic run_txn(input int sel, input logic ec, input logic [2:0] em, input tup_t ew,
                         input string nm);
    int nch, vc;
    logic oc, oe;
    logic [2:0] om, ordy, xm;
    tup_t ot, xw;
    nch = (sel == 0) ? 3 : 2;
    vc = vote_cyc(nch);
    for (int k = 0; k <= vc + 2; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        oc = c3; oe = e3; om = m3; ordy = r3; ot = {w3o, ao3, do3};
      end else begin
        oc = c2; oe = e2; om = {1'b0, m2}; ordy = {1'b0, r2}; ot = {w2o, ao2, do2};
      end
      xm = (k >= vc + 1) ? em : last_m[sel];
      xw = (k >= vc + 1 && ec) ? ew : last_w[sel];
      chk({nm, " commit"}, 64'(oc), 64'(ec && k == vc + 1));
      chk({nm, " error"}, 64'(oe), 64'((|em) && k == vc + 1));
      chk({nm, " mask"}, 64'(om), 64'(xm));
      chk({nm, " wb_tuple"}, 64'(ot), 64'(xw));
      v3 = '0; v2 = '0;
      for (int i = 0; i < nch; i++) begin
        if (cur_arr[i] == k) begin
          chk({nm, " ready"}, 64'(ordy[i]), 64'd1);
          if (sel == 0) begin
            v3[i] = 1'b1; we3[i] = cur_t[i].we;
            a3[i*5 +: 5] = cur_t[i].addr; d3[i*32 +: 32] = cur_t[i].data;
          end else begin
            v2[i] = 1'b1; we2[i] = cur_t[i].we;
            a2[i*5 +: 5] = cur_t[i].addr; d2[i*32 +: 32] = cur_t[i].data;
          end
        end
      end
    end
    v3 = '0; v2 = '0;
    last_m[sel] = em;
    if (ec) last_w[sel] = ew;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      last_w[s] = '0;
      last_m[s] = 3'b000;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[11];

  initial begin
    tup_t tb1, tx, ty, tz;
    logic mc;
    logic [2:0] mm;
    tup_t mw;

    tb1 = mk(1'b1, 5'd5, 32'hDEADBEEF);
    tx  = mk(1'b1, 5'd2, 32'h00001234);
    ty  = mk(1'b0, 5'd7, 32'h0000A5A5);
    tz  = mk(1'b1, 5'd9, 32'h00C0FFEE);
    tbl[0]  = '{"all_agree", 3, 0, 0, 0, tb1, tb1, tb1, 1'b1, 3'b000, tb1};
    tbl[1]  = '{"ch1_data", 3, 0, 0, 0, tx, mk(1'b1, 5'd2, 32'h0), tx, 1'b1, 3'b010, tx};
    tbl[2]  = '{"timeout_ch2", 3, 0, 3, -1, ty, ty, tz, 1'b1, 3'b100, ty};
    tbl[3]  = '{"no_majority", 3, 1, 0, 2, tx, ty, tz, 1'b0, 3'b111, tx};
    tbl[4]  = '{"last_at_timeout", 3, 0, 0, 16, tz, tz, tz, 1'b1, 3'b000, tz};
    tbl[5]  = '{"ch2_we", 3, 2, 2, 2, tz, tz, mk(1'b0, 5'd9, 32'h00C0FFEE), 1'b1, 3'b100, tz};
    tbl[6]  = '{"ch0_dissent", 3, 4, 1, 6, tx, ty, ty, 1'b1, 3'b001, ty};
    tbl[7]  = '{"only_ch1", 3, -1, 2, -1, tx, ty, tz, 1'b0, 3'b111, tx};
    tbl[8]  = '{"two_addr", 2, 0, 0, -1, mk(1'b1, 5'd3, 32'h55), mk(1'b1, 5'd4, 32'h55), tz, 1'b0, 3'b011, tz};
    tbl[9]  = '{"two_agree", 2, 0, 5, -1, ty, ty, tz, 1'b1, 3'b000, ty};
    tbl[10] = '{"two_missing", 2, 1, -1, -1, tx, ty, tz, 1'b0, 3'b011, tx};

    v3 = '0; we3 = '0; a3 = '0; d3 = '0;
    v2 = '0; we2 = '0; a2 = '0; d2 = '0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst commit3", 64'(c3), 64'd0);
    chk("rst error3", 64'(e3), 64'd0);
    chk("rst mask3", 64'(m3), 64'd0);
    chk("rst tuple3", 64'({w3o, ao3, do3}), 64'd0);
    chk("rst tuple2", 64'({w2o, ao2, do2}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready3", 64'(r3), 64'h7);
    chk("rst ready2", 64'(r2), 64'h3);

    for (int n = 0; n < 11; n++) begin
      cur_arr[0] = tbl[n].a0; cur_arr[1] = tbl[n].a1; cur_arr[2] = tbl[n].a2;
      cur_t[0] = tbl[n].t0; cur_t[1] = tbl[n].t1; cur_t[2] = tbl[n].t2;
      run_txn((tbl[n].nch == 3) ? 0 : 1, tbl[n].ec, tbl[n].em, tbl[n].ew, tbl[n].nm);
    end

    // Reset while one channel is latched and the others are still missing.
    @(negedge clk);
    v3[0] = 1'b1; we3[0] = 1'b1; a3[4:0] = 5'd11; d3[31:0] = 32'h0BAD0BAD;
    chk("rstcol ready", 64'(r3[0]), 64'd1);
    @(negedge clk);
    v3 = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstcol async tuple", 64'({w3o, ao3, do3}), 64'd0);
    chk("rstcol async mask", 64'(m3), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstcol commit", 64'(c3), 64'd0);
      chk("rstcol error", 64'(e3), 64'd0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("rstcol idle commit", 64'(c3), 64'd0);
      chk("rstcol idle error", 64'(e3), 64'd0);
      chk("rstcol ready3", 64'(r3), 64'h7);
    end
    cur_arr[0] = 0; cur_arr[1] = 0; cur_arr[2] = 0;
    cur_t[0] = tb1; cur_t[1] = tb1; cur_t[2] = tb1;
    run_txn(0, 1'b1, 3'b000, tb1, "after_reset");

    for (int n = 0; n < 160; n++) begin
      int nch, sel;
      sel = (n % 4 == 3) ? 1 : 0;
      nch = (sel == 0) ? 3 : 2;
      tx = rnd_tup();
      for (int i = 0; i < 3; i++) begin
        cur_t[i] = ($urandom_range(0, 2) == 0) ? corrupt(tx) : tx;
        cur_arr[i] = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 16);
      end
      if ($urandom_range(0, 7) == 0) cur_t[2] = cur_t[1];
      if (cur_arr[0] < 0 && cur_arr[1] < 0 && (nch == 2 || cur_arr[2] < 0)) cur_arr[0] = 0;
      model_vote(nch, mc, mm, mw);
      run_txn(sel, mc, mm, mw, "random");
    end

`ifdef WB_VOTER_ERRCNT_EN
    do_reset();
    for (int n = 0; n < 300; n++) begin
      tx = rnd_tup();
      cur_arr[0] = 0; cur_arr[1] = 0; cur_arr[2] = 0;
      cur_t[0] = tx; cur_t[1] = tx; cur_t[2] = corrupt(tx);
      run_txn(0, 1'b1, 3'b100, tx, "errcnt");
    end
    chk("errcnt ch0", 64'(cnt3[7:0]), 64'd0);
    chk("errcnt ch1", 64'(cnt3[15:8]), 64'd0);
    chk("errcnt ch2", 64'(cnt3[23:16]), 64'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
